// File: rtl/seq_mag_comp_pkg.sv
// Shared types and sizing helpers for the iterative slice-based magnitude comparator.
package seq_mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int slices_of(input int width);
    return width / 2;
  endfunction

  // A single slice still needs a 1-bit index so the counter has a real register.
  function automatic int idx_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/seq_mag_comp_cmp2_slice.sv
// Combinational 2-bit unsigned compare with one-hot equal/less/greater outputs.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       e,
  output logic       l,
  output logic       g
);

  assign e = (a == b);
  assign l = (a < b);
  assign g = (a > b);

endmodule

// File: rtl/seq_mag_comp.sv
// Sequences one 2-bit slice comparator MSB-first over latched operands,
// stopping at the first unequal slice; result returned over valid/ready.
module seq_mag_comp
  import seq_mag_comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int SLICES = slices_of(WIDTH);
  localparam int IDX_W  = idx_width(SLICES);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SLICES - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               out_valid_reg;
  logic               eq_reg;
  logic               lt_reg;
  logic               gt_reg;

  logic [SLICES-1:0][1:0] a_slices;
  logic [SLICES-1:0][1:0] b_slices;
  logic [1:0]             a_sel;
  logic [1:0]             b_sel;
  logic                   slice_e;
  logic                   slice_l;
  logic                   slice_g;

  for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
    assign a_slices[gi] = a_reg[2*gi +: 2];
    assign b_slices[gi] = b_reg[2*gi +: 2];
  end

  // Decoded mux so an index value never addresses past the last slice.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_sel = a_slices[i];
        b_sel = b_slices[i];
      end
    end
  end

  cmp2_slice u_slice (
    .a (a_sel),
    .b (b_sel),
    .e (slice_e),
    .l (slice_l),
    .g (slice_g)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      idx_reg       <= IDX_TOP;
      out_valid_reg <= 1'b0;
      eq_reg        <= 1'b0;
      lt_reg        <= 1'b0;
      gt_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            idx_reg   <= IDX_TOP;
            state_reg <= CMP;
          end
        end
        CMP: begin
          if (!slice_e) begin
            eq_reg        <= 1'b0;
            lt_reg        <= slice_l;
            gt_reg        <= slice_g;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else if (idx_reg == '0) begin
            eq_reg        <= 1'b1;
            lt_reg        <= 1'b0;
            gt_reg        <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            eq_reg        <= 1'b0;
            lt_reg        <= 1'b0;
            gt_reg        <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign eq        = eq_reg;
  assign lt        = lt_reg;
  assign gt        = gt_reg;

endmodule
